kpn_fifo_channel: RTL and testbench
===================================

KPN_FIFO_CHANNEL -- requirements
Module: kpn_fifo_channel

Interface
REQ-001 SHALL have parameter WIDTH, default 16, channel word width in 12.4 fixed-point format (bits [15:4] integer, bits [3:0] decimal digit 0-9).
REQ-002 SHALL have parameter DEPTH, default 8, number of stored words (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr  input  1  write strobe from the producer process node.
REQ-006 SHALL have port data_in  input  WIDTH  word to write.
REQ-007 SHALL have port rd  input  1  read strobe from the consumer process node.
REQ-008 SHALL have port data_out  output  WIDTH  last word read, registered.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse when data_out holds a newly read word.
REQ-010 SHALL have port full  output  1  high when count == DEPTH.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  number of stored words.
REQ-013 SHALL have port overflow  output  1  sticky: a write was refused because the channel was full.
REQ-014 SHALL have port underflow  output  1  sticky: a read was refused because the channel was empty.
REQ-015 SHALL have port format_err  output  1  sticky: a written word had decimal nibble >= 10.

Function
REQ-016 SHALL evaluate wr and rd as level strobes, sampled once per rising clk edge.
REQ-017 SHALL accept a write when wr=1, the decimal nibble of data_in is <= 9, and either full=0 or (rd=1 and empty=0) in the same cycle.
REQ-018 SHALL store an accepted word at the write pointer and advance the pointer modulo DEPTH.
REQ-019 SHALL refuse a write when the decimal nibble is >= 10: word not stored, pointer and count unchanged, format_err set.
REQ-020 SHALL refuse a write when full=1 and no read is accepted in the same cycle: word not stored, overflow set.
REQ-021 SHALL accept a read when rd=1 and empty=0, based on the pre-edge state.
REQ-022 SHALL, on an accepted read, load data_out with the word at the read pointer, advance the pointer modulo DEPTH, and pulse out_valid for exactly one cycle.
REQ-023 SHALL, on rd=1 with empty=1, keep data_out unchanged, keep out_valid=0, and set underflow; a same-cycle write is still accepted, with no bypass to data_out.
REQ-024 SHALL hold data_out between accepted reads.
REQ-025 SHALL update count +1 on write-only, -1 on read-only, and leave it unchanged on simultaneous accepted write and read.
REQ-026 SHALL derive full and empty from the registered count, valid in the same cycle as the count.
REQ-027 SHALL have a one-cycle write-to-read latency: a word written at edge N is readable at edge N+1.
REQ-028 SHALL handle pointer wrap-around transparently; FIFO order is preserved across any number of wraps.
REQ-029 SHALL keep overflow, underflow and format_err set until reset.

Reset
REQ-030 SHALL, on reset_n=0, immediately and asynchronously clear pointers, count, data_out (16'h0000), out_valid, overflow, underflow and format_err, with empty=1 and full=0.
REQ-031 SHALL discard all stored words on reset, including during an in-progress write or read; the first accepted write after release is the first word read.
REQ-032 SHALL ignore wr and rd while reset_n=0.

Verification
REQ-033 SHALL verify write then read: write 16'h0125 (18.5), next cycle rd -> data_out=16'h0125, out_valid one cycle, count 1->0, empty=1.
REQ-034 SHALL verify fill and overflow: write 8 words 16'h0010..16'h0080, then a 9th (16'h0090) -> full=1, overflow=1, count=8; reads return 0x10..0x80 in order.
REQ-035 SHALL verify full simultaneous access: at count=8, wr (16'h0099) and rd together -> data_out=first word, count stays 8, overflow stays 0, 16'h0099 read last.
REQ-036 SHALL verify empty access: rd on empty with wr 16'h0033 -> underflow=1, out_valid=0, data_out unchanged, count=1; next rd gives 16'h0033.
REQ-037 SHALL verify format check: write 16'h001A -> format_err=1, count unchanged, empty unchanged.
REQ-038 SHALL verify wrap and reset: run 20 write/read pairs (wrap twice) with order checked, write 3 words, assert reset_n mid-cycle -> outputs cleared at once and count=0; after release, write 16'h0042 and read it back.

Source files
------------

// File: rtl/kpn_fifo_channel.sv
// rtl/kpn_fifo_channel.sv - KPN channel FIFO with 12.4 decimal format check and sticky error flags
module kpn_fifo_channel #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     format_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_format_err;

  logic w_full;
  logic w_empty;
  logic w_fmt_ok;
  logic w_rd_ok;
  logic w_wr_ok;

  // Full/empty come straight from the registered count so they track it in the same cycle.
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Decimal digit field must hold 0..9; anything else is not a legal 12.4 word.
  assign w_fmt_ok = (data_in[3:0] <= 4'd9);
  assign w_rd_ok  = rd & ~w_empty;
  // A full channel still takes a write when a read frees a slot on the same edge.
  assign w_wr_ok  = wr & w_fmt_ok & (~w_full | w_rd_ok);

  // Storage array; no reset needed since only words behind a valid count are ever read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the pointer wrap implicit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port: data_out holds the last word read, out_valid pulses per read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_format_err <= 1'b0;
    end else begin
      if (wr & w_full & ~w_rd_ok) begin
        r_overflow <= 1'b1;
      end
      if (rd & w_empty) begin
        r_underflow <= 1'b1;
      end
      if (wr & ~w_fmt_ok) begin
        r_format_err <= 1'b1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign out_valid  = r_out_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign format_err = r_format_err;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb/tb_kpn_fifo_channel.sv - directed and randomized bench for kpn_fifo_channel
module tb_kpn_fifo_channel;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr;
  logic [15:0] data_in;
  logic        rd;
  logic [15:0] data_out;
  logic        out_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        format_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered list of stored words plus the observable registers.
  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic        m_valid;
  logic        m_ov;
  logic        m_uf;
  logic        m_fe;

  kpn_fifo_channel #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .data_in    (data_in),
    .rd         (rd),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .format_err (format_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_dout  = 16'h0000;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_uf    = 1'b0;
    m_fe    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},   32'(data_out),   32'(m_dout));
    chk({tag, ".out_valid"},  32'(out_valid),  32'(m_valid));
    chk({tag, ".count"},      32'(count),      32'(q.size()));
    chk({tag, ".full"},       32'(full),       32'(q.size() == DEPTH));
    chk({tag, ".empty"},      32'(empty),      32'(q.size() == 0));
    chk({tag, ".overflow"},   32'(overflow),   32'(m_ov));
    chk({tag, ".underflow"},  32'(underflow),  32'(m_uf));
    chk({tag, ".format_err"}, 32'(format_err), 32'(m_fe));
  endtask

  // One clock of stimulus, called just after a falling edge; checks after the next falling edge.
  task automatic step(input string tag, input logic w, input logic [15:0] d, input logic r);
    int   pre;
    logic rok;
    logic fok;
    logic wok;
    wr      = w;
    data_in = d;
    rd      = r;
    pre = q.size();
    rok = r && (pre > 0);
    fok = (d[3:0] <= 4'd9);
    wok = w && fok && ((pre < DEPTH) || rok);
    if (w && !fok) m_fe = 1'b1;
    if (w && (pre == DEPTH) && !rok) m_ov = 1'b1;
    if (r && !rok) m_uf = 1'b1;
    m_valid = rok;
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    check_all(tag);
  endtask

  // Assert reset mid-cycle, check the immediate clear, keep strobing during reset, then release.
  task automatic mid_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    check_all({tag, ".async"});
    wr      = 1'b1;
    rd      = 1'b1;
    data_in = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".held"});
    wr      = 1'b0;
    rd      = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    logic        w;
    logic        r;
    reset_n = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    data_in = 16'h0000;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // Write then read with one-cycle latency.
    step("wr0125", 1'b1, 16'h0125, 1'b0);
    chk("wr0125.count_is_1", 32'(count), 32'd1);
    step("rd0125", 1'b0, 16'h0000, 1'b1);
    chk("rd0125.dout_const", 32'(data_out), 32'h0125);
    chk("rd0125.valid_const", 32'(out_valid), 32'd1);
    step("idle", 1'b0, 16'h0000, 1'b0);
    chk("idle.valid_drop", 32'(out_valid), 32'd0);
    chk("idle.dout_hold", 32'(data_out), 32'h0125);

    // Fill to full, refused ninth write, drain in order.
    for (int k = 1; k <= 8; k++) step("fill", 1'b1, 16'(k * 16), 1'b0);
    step("ovf", 1'b1, 16'h0090, 1'b0);
    chk("ovf.full_const", 32'(full), 32'd1);
    chk("ovf.flag_const", 32'(overflow), 32'd1);
    chk("ovf.count_const", 32'(count), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      step("drain", 1'b0, 16'h0000, 1'b1);
      chk("drain.order_const", 32'(data_out), 32'(k * 16));
    end

    // Fresh channel, fill, then simultaneous write and read while full.
    @(negedge clk);
    mid_reset("rst1");
    for (int k = 1; k <= 8; k++) step("fill2", 1'b1, 16'(k * 16), 1'b0);
    step("fullrw", 1'b1, 16'h0099, 1'b1);
    chk("fullrw.dout_const", 32'(data_out), 32'h0010);
    chk("fullrw.count_const", 32'(count), 32'd8);
    chk("fullrw.ovf_const", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) step("drain2", 1'b0, 16'h0000, 1'b1);
    chk("drain2.last_const", 32'(data_out), 32'h0099);

    // Read on empty with a same-cycle write: no bypass.
    step("emptyrw", 1'b1, 16'h0033, 1'b1);
    chk("emptyrw.uf_const", 32'(underflow), 32'd1);
    chk("emptyrw.valid_const", 32'(out_valid), 32'd0);
    chk("emptyrw.dout_const", 32'(data_out), 32'h0099);
    chk("emptyrw.count_const", 32'(count), 32'd1);
    step("rd0033", 1'b0, 16'h0000, 1'b1);
    chk("rd0033.dout_const", 32'(data_out), 32'h0033);

    // Illegal decimal nibble is refused.
    step("fmt", 1'b1, 16'h001A, 1'b0);
    chk("fmt.flag_const", 32'(format_err), 32'd1);
    chk("fmt.count_const", 32'(count), 32'd0);
    chk("fmt.empty_const", 32'(empty), 32'd1);

    // Twenty write/read pairs wrap the pointers twice.
    for (int k = 0; k < 20; k++) begin
      d = {12'(k + 100), 4'(k % 10)};
      step("wrap_wr", 1'b1, d, 1'b0);
      step("wrap_rd", 1'b0, 16'h0000, 1'b1);
    end
    for (int k = 0; k < 3; k++) step("pre_rst", 1'b1, 16'(16'h0200 + k), 1'b0);
    mid_reset("rst2");
    step("post_wr", 1'b1, 16'h0042, 1'b0);
    step("post_rd", 1'b0, 16'h0000, 1'b1);
    chk("post_rd.dout_const", 32'(data_out), 32'h0042);

    // Randomized traffic, alternating write-heavy and read-heavy phases.
    @(negedge clk);
    mid_reset("rst3");
    for (int i = 0; i < 400; i++) begin
      if (((i / 40) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      d[15:4] = 12'($urandom);
      if ($urandom_range(0, 15) == 0) d[3:0] = 4'($urandom_range(10, 15));
      else d[3:0] = 4'($urandom_range(0, 9));
      step("rand", w, d, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
